// File: rtl/bt_pipe_out_buffer_pkg.sv
// Shared definitions for the block-throttled pipe-out buffer: controller
// state encoding, default geometry and the bus word width.
package pipe_test_pkg;

  // Bus word width seen by both the producer and the pipe-out endpoint.
  localparam int DATA_W = 32;

  // Default FIFO geometry: 2^10 = 1024 words, 256-word blocks.
  localparam int DEFAULT_ADDR_W      = 10;
  localparam int DEFAULT_BLOCK_WORDS = 256;

  // Block controller: IDLE between blocks, BURST while a block is read out.
  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_e;

endpackage : pipe_test_pkg

// File: rtl/bt_pipe_out_buffer_if.sv
// Producer and BTPipeOut endpoint handshake bundle for bt_pipe_out_buffer.
// "master" is the environment side (producer + endpoint), "slave" is the buffer.
interface bt_pipe_out_buffer_if;
  import pipe_test_pkg::*;

  // Producer side
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;

  // Endpoint side
  logic              ep_read;
  logic              ep_blockstrobe;
  logic [DATA_W-1:0] ep_datain;
  logic              ep_ready;

  modport master (
    output in_valid,
    output in_data,
    input  in_ready,
    output ep_read,
    output ep_blockstrobe,
    input  ep_datain,
    input  ep_ready
  );

  modport slave (
    input  in_valid,
    input  in_data,
    output in_ready,
    input  ep_read,
    input  ep_blockstrobe,
    output ep_datain,
    output ep_ready
  );

endinterface : bt_pipe_out_buffer_if

// File: rtl/bt_pipe_out_buffer_sdp_ram.sv
// Simple dual-port RAM: one write port, one read port with a registered,
// enable-gated output. No reset on the array or the read register so the
// whole thing maps onto a block RAM primitive.
module sdp_ram #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
  logic [DATA_W-1:0] rdata_q;

  // Write port: store the word on every enabled edge.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem[waddr_i] <= wdata_i;
    end
  end

  // Read port: output register only moves on a read, so it holds otherwise.
  always_ff @(posedge clk) begin
    if (re_i) begin
      rdata_q <= mem[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule : sdp_ram

// File: rtl/bt_pipe_out_buffer.sv
// Block-throttled pipe-out buffer. A producer pushes 32-bit words into a
// 2^ADDR_W-deep circular FIFO; the BTPipeOut endpoint pops them with a
// one-cycle read latency. ep_ready tells the endpoint a whole block is
// buffered, and a small IDLE/BURST controller tracks block progress.
module bt_pipe_out_buffer
  import pipe_test_pkg::*;
#(
  parameter int ADDR_W      = DEFAULT_ADDR_W,
  parameter int BLOCK_WORDS = DEFAULT_BLOCK_WORDS
) (
  input  logic                clk,
  input  logic                reset_n,
  bt_pipe_out_buffer_if.slave bus,
  output logic [ADDR_W:0]     fill_level,
  output logic [31:0]         underflow_count,
  output logic [31:0]         block_count
);

  // Full count has only the MSB set; the block threshold shares the count width.
  localparam logic [ADDR_W:0] DEPTH_C      = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] BLOCK_C      = (ADDR_W+1)'(BLOCK_WORDS);
  localparam logic [ADDR_W:0] BLOCK_LAST_C = BLOCK_C - (ADDR_W+1)'(1);

  // Counters stick at all-ones rather than wrapping back to a small value.
  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    sat_inc32 = (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q,  count_d;
  logic              ep_ready_q;
  logic              dvld_q;
  logic [31:0]       uf_cnt_q;
  logic [31:0]       blk_cnt_q;
  state_e            state_q;
  logic [ADDR_W:0]   word_cnt_q;

  logic              in_ready;
  logic              empty;
  logic              push;
  logic              pop;
  logic              underflow;
  logic [DATA_W-1:0] ram_rdata;

  // Handshake qualification, all from registered count so in_ready has no
  // combinational path from any input.
  assign in_ready  = (count_q != DEPTH_C);
  assign empty     = (count_q == '0);
  assign push      = bus.in_valid && in_ready;
  assign pop       = bus.ep_read && !empty;
  assign underflow = bus.ep_read && empty;

  // Pointer and occupancy next-state; a simultaneous push and pop leaves the count alone.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + ADDR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + ADDR_W'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + (ADDR_W+1)'(1);
      2'b01:   count_d = count_q - (ADDR_W+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // FIFO bookkeeping, block-ready flag and status counters.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      ep_ready_q <= 1'b0;
      dvld_q     <= 1'b0;
      uf_cnt_q   <= '0;
      blk_cnt_q  <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      // Looks at the post-edge count so the flag is never a cycle stale.
      ep_ready_q <= (count_d >= BLOCK_C);
      // Stays set once a word has been delivered; masks the unreset RAM register.
      if (pop) begin
        dvld_q <= 1'b1;
      end
      if (underflow) begin
        uf_cnt_q <= sat_inc32(uf_cnt_q);
      end
      if (bus.ep_blockstrobe) begin
        blk_cnt_q <= blk_cnt_q + 32'd1;
      end
    end
  end

  // Block controller: counts read strobes within a block; a fresh blockstrobe restarts it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      word_cnt_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.ep_blockstrobe) begin
            state_q    <= BURST;
            word_cnt_q <= '0;
          end
        end
        BURST: begin
          if (bus.ep_blockstrobe) begin
            word_cnt_q <= '0;
          end else if (bus.ep_read) begin
            if (word_cnt_q == BLOCK_LAST_C) begin
              state_q    <= IDLE;
              word_cnt_q <= '0;
            end else begin
              word_cnt_q <= word_cnt_q + (ADDR_W+1)'(1);
            end
          end
        end
        default: begin
          state_q    <= IDLE;
          word_cnt_q <= '0;
        end
      endcase
    end
  end

  // Storage: read port fires only on a real pop, so the output holds on underflow.
  sdp_ram #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_ram (
    .clk     (clk),
    .we_i    (push),
    .waddr_i (wr_ptr_q),
    .wdata_i (bus.in_data),
    .re_i    (pop),
    .raddr_i (rd_ptr_q),
    .rdata_o (ram_rdata)
  );

  assign bus.in_ready     = in_ready;
  assign bus.ep_ready     = ep_ready_q;
  assign bus.ep_datain    = dvld_q ? ram_rdata : '0;
  assign fill_level       = count_q;
  assign underflow_count  = uf_cnt_q;
  assign block_count      = blk_cnt_q;

endmodule : bt_pipe_out_buffer

// File: doc/bt_pipe_out_buffer.md
BT_PIPE_OUT_BUFFER -- requirements
Module: bt_pipe_out_buffer

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, log2 of FIFO depth (DEPTH = 2^ADDR_W words).
REQ-002 SHALL have parameter BLOCK_WORDS, default 256, 32-bit words per block-throttled transfer; legal range 1..DEPTH.
REQ-003 SHALL have port clk, input, 1, single clock for all logic (okClk domain).
REQ-004 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port in_valid, input, 1, producer word valid.
REQ-006 SHALL have port in_data, input, 32, producer word.
REQ-007 SHALL have port in_ready, output, 1, buffer can accept a word this cycle.
REQ-008 SHALL have port ep_read, input, 1, pipe-out read strobe from the BTPipeOut endpoint.
REQ-009 SHALL have port ep_blockstrobe, input, 1, one-cycle pulse marking the start of a block.
REQ-010 SHALL have port ep_datain, output, 32, word delivered to the endpoint.
REQ-011 SHALL have port ep_ready, output, 1, a full block is available.
REQ-012 SHALL have port fill_level, output, ADDR_W+1, current word count.
REQ-013 SHALL have port underflow_count, output, 32, reads issued while empty.
REQ-014 SHALL have port block_count, output, 32, blockstrobes received.

Function
REQ-015 SHALL store words in a DEPTH x 32 circular buffer with ADDR_W-bit write/read pointers that wrap from DEPTH-1 to 0.
REQ-016 SHALL drive in_ready = (fill_level != DEPTH), combinationally from registered count.
REQ-017 SHALL write in_data at wr_ptr and increment wr_ptr on each edge where in_valid && in_ready.
REQ-018 SHALL, on an edge where ep_read=1 and fill_level>0, load ep_datain with mem[rd_ptr] and increment rd_ptr; data valid from that edge (one-cycle read latency).
REQ-019 SHALL, on ep_read=1 with fill_level=0, hold ep_datain and pointers and increment underflow_count (saturating at 2^32-1).
REQ-020 SHALL update fill_level +1 on push only, -1 on pop only, unchanged on simultaneous push and pop.
REQ-021 SHALL accept simultaneous push and pop when full (in_ready=0 blocks the push) and when empty (pop is an underflow; push lands).
REQ-022 SHALL register ep_ready = (next fill_level >= BLOCK_WORDS), so it reflects the count after the current edge.
REQ-023 SHALL increment block_count (wrapping) on each edge with ep_blockstrobe=1, independent of fill state.
REQ-024 SHALL implement a 2-state controller IDLE/BURST: IDLE->BURST on ep_blockstrobe; BURST->IDLE after BLOCK_WORDS ep_read strobes counted; blockstrobe in BURST restarts the word counter.
REQ-025 SHALL count an ep_read in IDLE as a valid pop but not as block progress.

Reset
REQ-026 SHALL, while reset_n=0, asynchronously clear pointers, fill_level, ep_datain, ep_ready, underflow_count, block_count and set state IDLE; in_ready reads 1 after reset.
REQ-027 SHALL discard buffered contents on reset mid-transfer; memory array itself is not reset.
REQ-028 SHALL release reset synchronously to clk at the instantiating level (not inside this block).

Structure
REQ-029 SHALL place the state enum (IDLE, BURST) and default ADDR_W/BLOCK_WORDS constants in shared package pipe_test_pkg.
REQ-030 SHALL use one sub-module, sdp_ram (simple dual-port, registered read, inferable to block RAM), for storage.

Verification
REQ-031 SHALL cover: 255 pushes -> ep_ready=0; 256th push -> ep_ready=1 after that edge, fill_level=256.
REQ-032 SHALL cover: pushes of 0x00000000..0x000003FF (1024) -> in_ready=0 at fill_level=1024; further in_valid ignored; reading 1024 returns same sequence in order.
REQ-033 SHALL cover: blockstrobe + 256 reads on 256 stored words -> data 0..255 each one cycle after its ep_read, state returns IDLE, ep_ready=0, block_count=1.
REQ-034 SHALL cover: 3 ep_read strobes on empty buffer -> underflow_count=3, ep_datain unchanged, fill_level=0.
REQ-035 SHALL cover: continuous push+pop at fill_level=512 for 2000 cycles -> fill_level stays 512, pointers wrap, no data error.
REQ-036 SHALL cover: reset_n low mid-burst at fill_level=300 -> all outputs zero same cycle, in_ready=1, state IDLE.
